// File: rtl/bus_cycle_ctrl_if.sv
// Requester + external memory bus bundle for bus_cycle_ctrl.
// Latency: n/a (wires only).
// Backpressure: none here; the controller ignores req while busy.
//
// slave modport is the controller side. master modport is the side that
// drives requests and models the memory (the requester/memory environment).
`timescale 1ns/1ps
interface bus_cycle_ctrl_if;
  // requester handshake
  logic        req;
  logic        we;
  logic        word;
  logic [19:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        err;
  // external 16-bit memory bus
  logic [19:0] mem_addr;
  logic        mem_ale;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ble;
  logic        mem_bhe;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  req, we, word, addr, wdata, mem_rdata, mem_ready,
    output busy, done, rdata, err,
    output mem_addr, mem_ale, mem_rd, mem_wr, mem_ble, mem_bhe, mem_wdata
  );

  modport master (
    output req, we, word, addr, wdata, mem_rdata, mem_ready,
    input  busy, done, rdata, err,
    input  mem_addr, mem_ale, mem_rd, mem_wr, mem_ble, mem_bhe, mem_wdata
  );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// 8086-style bus cycle controller: T1-T4 cycles with wait states and byte-lane steering.
// Latency: 4 cycles per aligned access (+1 per wait state); odd word = two cycles (8 + waits).
// Backpressure: mem_ready stretches T3 into TW; req is ignored while busy, never queued.
//
// Ports: clk, rst (async active-high) plus the slave modport of
// bus_cycle_ctrl_if (requester req/we/word/addr/wdata -> busy/done/rdata/err,
// memory mem_addr/mem_ale/mem_rd/mem_wr/mem_ble/mem_bhe/mem_wdata <- mem_rdata/mem_ready).
// Optional feature macro: BUS_TIMEOUT_EN (abort after WAIT_MAX wait states, err=1).
`timescale 1ns/1ps
module bus_cycle_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  bus_cycle_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_TW   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;

  logic [2:0]  state;
  logic        lat_we;
  logic        lat_word;
  logic        lat_odd;     // addr[0] of the original request
  logic [19:0] cur_addr;    // address of the bus cycle in progress
  logic [15:0] lat_wdata;
  logic        second;      // running the second half of an odd word
  logic        split_pend;  // first half of an odd word; another cycle follows
  logic [7:0]  lo_byte;     // low result byte held between the two halves
  logic [15:0] rdata_q;
  logic        tmo;         // wait-state timeout fires on this edge
  logic        cap;         // read data captured on this edge
  logic        waiting;

  assign waiting = (state == S_T3) || (state == S_TW);
  assign cap     = waiting && bus.mem_ready && !lat_we;

  //--------------------------------------------------------------------------
  // Optional wait-state timeout
  //--------------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] wait_cnt;
  logic          abort_q;

  // Counts TW cycles already spent; the abort edge is the one ending the
  // WAIT_MAX-th TW, which is when the count reaches WAIT_MAX-1 here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == S_T3) begin
      wait_cnt <= '0;
    end else if (state == S_TW && !bus.mem_ready) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign tmo = (state == S_TW) && !bus.mem_ready && (wait_cnt == CW'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_q <= 1'b0;
    end else if (state == S_IDLE && bus.req) begin
      abort_q <= 1'b0;
    end else if (tmo) begin
      abort_q <= 1'b1;
    end
  end

  assign bus.err = bus.done & abort_q;
`else
  logic [31:0] unused_wait_max;
  assign unused_wait_max = 32'(WAIT_MAX);
  assign tmo     = 1'b0;
  assign bus.err = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // Bus cycle FSM and request latches
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_we     <= 1'b0;
      lat_word   <= 1'b0;
      lat_odd    <= 1'b0;
      cur_addr   <= '0;
      lat_wdata  <= '0;
      second     <= 1'b0;
      split_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            state      <= S_T1;
            lat_we     <= bus.we;
            lat_word   <= bus.word;
            lat_odd    <= bus.addr[0];
            cur_addr   <= bus.addr;
            lat_wdata  <= bus.wdata;
            second     <= 1'b0;
            split_pend <= bus.word & bus.addr[0];
          end
        end
        S_T1: state <= S_T2;
        S_T2: state <= S_T3;
        S_T3, S_TW: begin
          if (bus.mem_ready) begin
            state <= S_T4;
          end else if (tmo) begin
            // abort: finish this access now, dropping any pending half
            state      <= S_T4;
            split_pend <= 1'b0;
          end else begin
            state <= S_TW;
          end
        end
        S_T4: begin
          if (split_pend) begin
            state      <= S_T1;
            second     <= 1'b1;
            split_pend <= 1'b0;
            cur_addr   <= cur_addr + 20'd1;  // wraps 0xFFFFF -> 0x00000
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Read data capture
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      lo_byte <= '0;
    end else if (tmo) begin
      rdata_q <= '0;
    end else if (cap) begin
      if (!lat_word) begin
        // byte read: the addressed lane lands in [7:0], zero-extended
        rdata_q <= {8'h00, (lat_odd ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0])};
      end else if (!lat_odd) begin
        rdata_q <= bus.mem_rdata;
      end else if (!second) begin
        // odd word, first half: low byte arrives on the high lane
        lo_byte <= bus.mem_rdata[15:8];
      end else begin
        // odd word, second half: high byte arrives on the low lane
        rdata_q <= {bus.mem_rdata[7:0], lo_byte};
      end
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  logic busy_c;
  logic strobe;

  assign busy_c      = (state != S_IDLE);
  assign strobe      = (state == S_T2) || waiting;
  assign bus.busy    = busy_c;
  assign bus.done    = (state == S_T4) && !split_pend;
  assign bus.rdata   = rdata_q;
  assign bus.mem_ale = (state == S_T1);
  assign bus.mem_rd  = strobe & !lat_we;
  assign bus.mem_wr  = strobe & lat_we;
  assign bus.mem_addr = busy_c ? cur_addr : 20'd0;

  // Lane selection follows the address of the current cycle: bytes and the
  // halves of an odd word use one lane each, an even word uses both.
  always_comb begin
    bus.mem_ble   = 1'b0;
    bus.mem_bhe   = 1'b0;
    bus.mem_wdata = 16'h0000;
    if (busy_c) begin
      if (lat_word && !lat_odd) begin
        bus.mem_ble = 1'b1;
        bus.mem_bhe = 1'b1;
      end else begin
        bus.mem_ble = !cur_addr[0];
        bus.mem_bhe = cur_addr[0];
      end
      if (lat_we) begin
        if (!lat_word) begin
          bus.mem_wdata = lat_odd ? {lat_wdata[7:0], 8'h00} : {8'h00, lat_wdata[7:0]};
        end else if (!lat_odd) begin
          bus.mem_wdata = lat_wdata;
        end else if (!second) begin
          bus.mem_wdata = {lat_wdata[7:0], 8'h00};
        end else begin
          bus.mem_wdata = {8'h00, lat_wdata[15:8]};
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed accesses checked cycle by cycle.
// Latency: n/a.
// Backpressure: memory ready is driven per access (wait-state count per half).
`timescale 1ns/1ps
module tb_bus_cycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_cycle_ctrl_if bif ();

  bus_cycle_ctrl #(.WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_rdata = 16'h0000;  // model of the held read result

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access: drives req, then checks every cycle up to the first idle cycle.
  task automatic run_access(input logic w, input logic wd, input logic [19:0] a,
                            input logic [15:0] wdat, input logic [15:0] r1,
                            input logic [15:0] r2, input int wt1, input int wt2,
                            input int exp_done_cyc);
    int          nh;
    int          cyc;
    int          wt;
    logic [19:0] ha;
    logic        hble, hbhe, last;
    logic [15:0] hwd, rv;
    exp_t        e, got;
    nh = (wd && a[0]) ? 2 : 1;
    if (!w) begin
      if (!wd)       exp_rdata = {8'h00, (a[0] ? r1[15:8] : r1[7:0])};
      else if (!a[0]) exp_rdata = r1;
      else           exp_rdata = {r2[7:0], r1[15:8]};
    end
    e.rdata = exp_rdata;
    e.err   = 1'b0;
    sb.push_back(e);

    bif.req = 1'b1; bif.we = w; bif.word = wd; bif.addr = a; bif.wdata = wdat;
    step();
    // scramble inputs after acceptance: the controller must use latched copies
    bif.req = 1'b0; bif.we = ~w; bif.word = ~wd; bif.addr = ~a; bif.wdata = ~wdat;
    cyc = 1;
    for (int h = 0; h < nh; h++) begin
      ha = (h == 0) ? a : a + 20'd1;
      if (!wd) begin
        hble = ~a[0]; hbhe = a[0];
        hwd  = a[0] ? {wdat[7:0], 8'h00} : {8'h00, wdat[7:0]};
      end else if (!a[0]) begin
        hble = 1'b1; hbhe = 1'b1; hwd = wdat;
      end else if (h == 0) begin
        hble = 1'b0; hbhe = 1'b1; hwd = {wdat[7:0], 8'h00};
      end else begin
        hble = 1'b1; hbhe = 1'b0; hwd = {8'h00, wdat[15:8]};
      end
      wt   = (h == 0) ? wt1 : wt2;
      rv   = (h == 0) ? r1 : r2;
      last = (h == nh - 1);
      // T1
      chk("t1_ale", bif.mem_ale, 1);
      chk("t1_strobes", {bif.mem_rd, bif.mem_wr}, 0);
      chk("t1_busy", bif.busy, 1);
      chk("t1_addr", bif.mem_addr, ha);
      chk("t1_lanes", {bif.mem_ble, bif.mem_bhe}, {hble, hbhe});
      chk("t1_done", bif.done, 0);
      step(); cyc++;
      // T2, T3 and wait states
      for (int i = 0; i < 2 + wt; i++) begin
        bif.mem_ready = (i == 1 + wt);
        bif.mem_rdata = (i == 1 + wt) ? rv : 16'hDEAD;
        chk("strb_ale", bif.mem_ale, 0);
        chk("strb_rdwr", {bif.mem_rd, bif.mem_wr}, {~w, w});
        chk("strb_addr", bif.mem_addr, ha);
        chk("strb_lanes", {bif.mem_ble, bif.mem_bhe}, {hble, hbhe});
        chk("strb_done", bif.done, 0);
        chk("strb_busy", bif.busy, 1);
        if (w) chk("strb_wdata", bif.mem_wdata, hwd);
        step(); cyc++;
      end
      bif.mem_ready = 1'b0;
      bif.mem_rdata = 16'h0000;
      // T4
      chk("t4_strobes", {bif.mem_ale, bif.mem_rd, bif.mem_wr}, 0);
      chk("t4_busy", bif.busy, 1);
      chk("t4_done", bif.done, last);
      if (last) begin
        chk("done_cycle", cyc, exp_done_cyc);
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          got = sb.pop_front();
          chk("rdata", bif.rdata, got.rdata);
          chk("err", bif.err, got.err);
        end
      end
      step(); cyc++;
    end
    chk("idle_busy", bif.busy, 0);
    chk("idle_done", bif.done, 0);
  endtask

  initial begin
    rst = 1'b1;
    bif.req = 1'b0; bif.we = 1'b0; bif.word = 1'b0; bif.addr = '0; bif.wdata = '0;
    bif.mem_rdata = '0; bif.mem_ready = 1'b0;
    step(); step();
    chk("rst_busy", bif.busy, 0);
    chk("rst_done_err", {bif.done, bif.err}, 0);
    chk("rst_rdata", bif.rdata, 0);
    chk("rst_addr", bif.mem_addr, 0);
    chk("rst_strobes", {bif.mem_ale, bif.mem_rd, bif.mem_wr, bif.mem_ble, bif.mem_bhe}, 0);
    rst = 1'b0;
    step();

    // aligned word read, zero waits
    run_access(1'b0, 1'b1, 20'h12340, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 4);
    // odd byte write, back-to-back with the previous access
    run_access(1'b1, 1'b0, 20'h12341, 16'h00A5, 16'h0000, 16'h0000, 0, 0, 4);
    // odd word read across the top of the address space
    run_access(1'b0, 1'b1, 20'hFFFFF, 16'h0000, 16'h3400, 16'h0012, 0, 0, 8);
    // aligned read with three wait states
    run_access(1'b0, 1'b1, 20'h0ABC0, 16'h0000, 16'h5A5A, 16'h0000, 3, 0, 7);
    // byte reads on both lanes
    run_access(1'b0, 1'b0, 20'h00010, 16'h0000, 16'h77CC, 16'h0000, 0, 0, 4);
    run_access(1'b0, 1'b0, 20'h00011, 16'h0000, 16'h77CC, 16'h0000, 1, 0, 5);
    // odd word write with waits in both halves, then even word write
    run_access(1'b1, 1'b1, 20'h00021, 16'hA1B2, 16'h0000, 16'h0000, 1, 2, 11);
    run_access(1'b1, 1'b1, 20'h00030, 16'hC3D4, 16'h0000, 16'h0000, 0, 0, 4);
    // even byte write
    run_access(1'b1, 1'b0, 20'h00040, 16'h9966, 16'h0000, 16'h0000, 0, 0, 4);

    // reset in T2 of a write
    bif.req = 1'b1; bif.we = 1'b1; bif.word = 1'b1; bif.addr = 20'h00400; bif.wdata = 16'h1111;
    step();
    bif.req = 1'b0;
    step();
    chk("pre_rst_wr", bif.mem_wr, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wr", bif.mem_wr, 0);
    chk("mid_rst_busy", bif.busy, 0);
    chk("mid_rst_addr", bif.mem_addr, 0);
    chk("mid_rst_done", bif.done, 0);
    chk("mid_rst_rdata", bif.rdata, 0);
    exp_rdata = 16'h0000;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", bif.busy, 0);
    chk("post_rst_done", bif.done, 0);
    run_access(1'b0, 1'b1, 20'h00402, 16'h0000, 16'h4242, 16'h0000, 0, 0, 4);

`ifdef BUS_TIMEOUT_EN
    // memory never ready: abort after 15 wait states
    begin
      exp_t e, got;
      e.rdata = 16'h0000;
      e.err   = 1'b1;
      sb.push_back(e);
      exp_rdata = 16'h0000;
      bif.mem_ready = 1'b0;
      bif.req = 1'b1; bif.we = 1'b0; bif.word = 1'b1; bif.addr = 20'h00101;
      step();
      bif.req = 1'b0;
      chk("tmo_t1_ale", bif.mem_ale, 1);
      step(); step();
      for (int i = 0; i < 16; i++) begin
        chk("tmo_wait_rd", {bif.busy, bif.mem_rd, bif.done}, 3'b110);
        step();
      end
      chk("tmo_done", bif.done, 1);
      got = sb.pop_front();
      chk("tmo_err", bif.err, got.err);
      chk("tmo_rdata", bif.rdata, got.rdata);
      step();
      chk("tmo_idle", bif.busy, 0);
    end
`else
    // memory not ready for 110 cycles: busy must hold throughout
    run_access(1'b0, 1'b1, 20'h00100, 16'h0000, 16'hC0DE, 16'h0000, 110, 0, 114);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
